// File: rtl/wb_pkg.sv
// wb_pkg: shared select codes, requester indices and FSM state type for the write-back arbiter.
package wb_pkg;
  localparam logic [3:0] SRC_ALU      = 4'd0;
  localparam logic [3:0] SRC_LOADSIZE = 4'd1;
  localparam logic [3:0] SRC_MEMDATA  = 4'd2;
  localparam logic [3:0] SRC_RD       = 4'd3;
  localparam logic [3:0] SRC_SE1_32   = 4'd4;
  localparam logic [3:0] SRC_CONST227 = 4'd5;
  localparam logic [3:0] SRC_REGB     = 4'd6;
  localparam logic [3:0] SRC_HI       = 4'd7;
  localparam logic [3:0] SRC_LO       = 4'd8;
  localparam logic [3:0] SRC_MAX      = SRC_LO;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MDU  = 2;
  typedef enum logic {IDLE, WRITE} state_t;
  function automatic logic src_legal(input logic [3:0] s);
    return s <= SRC_MAX;
  endfunction
endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: one-hot grant from a 3-bit request; fixed LOAD>MDU>ALU, or round robin when WB_RR_EN is defined.
module wb_rr_picker
  import wb_pkg::*;
(
`ifdef WB_RR_EN
  input  logic       clk,
  input  logic       reset_n,
`endif
  input  logic [2:0] req,
  output logic [2:0] gnt
);
`ifdef WB_RR_EN
  logic [1:0] ptr, idx1, idx2;
  // search order: ptr, then the next two indices modulo 3
  always_comb begin
    idx1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    idx2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    gnt  = req[ptr]  ? 3'b001 << ptr  :
           req[idx1] ? 3'b001 << idx1 :
           req[idx2] ? 3'b001 << idx2 : 3'b000;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= 2'(REQ_LOAD);
    else if (|gnt) ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
`else
  assign gnt = req[REQ_LOAD] ? 3'b010 :
               req[REQ_MDU]  ? 3'b100 :
               req[REQ_ALU]  ? 3'b001 : 3'b000;
`endif
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates three write-back requesters onto one register-file write port, latency 1.
// Round-robin arbitration is compiled in when WB_RR_EN is defined; fixed priority otherwise.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req_valid,
  output logic [2:0] req_ready,
  input  logic [4:0] req0_dst,
  input  logic [4:0] req1_dst,
  input  logic [4:0] req2_dst,
  input  logic [3:0] req0_src,
  input  logic [3:0] req1_src,
  input  logic [3:0] req2_src,
  input  logic       wb_stall,
  output logic [3:0] MemtoReg,
  output logic [4:0] WriteReg,
  output logic       RegWrite,
  output logic       wb_busy,
  output logic       err_illegal
);
  state_t     state, state_nxt;
  logic [4:0] dst_q;
  logic [3:0] src_q;
  logic [2:0] gnt;
  logic       legal;
  // requests are masked in reset so req_ready is low regardless of clk
  wb_rr_picker u_picker (
`ifdef WB_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .req     (req_valid & {3{reset_n & ~wb_stall}}),
    .gnt     (gnt)
  );
  assign req_ready = gnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      dst_q <= '0;
      src_q <= SRC_ALU;
    end else begin
      state <= state_nxt;
      if (|gnt) begin
        dst_q <= gnt[1] ? req1_dst : gnt[2] ? req2_dst : req0_dst;
        src_q <= gnt[1] ? req1_src : gnt[2] ? req2_src : req0_src;
      end
    end
  always_comb state_nxt = |gnt ? WRITE : IDLE;
  always_comb begin
    wb_busy     = state == WRITE;
    legal       = src_legal(src_q);
    RegWrite    = wb_busy & legal & |dst_q;
    MemtoReg    = wb_busy & legal ? src_q : SRC_ALU;
    WriteReg    = dst_q;
    err_illegal = wb_busy & ~legal;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors with a spec-level model compared every cycle, plus literal spot checks.
module tb_wb_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_ready;
  logic [4:0] req0_dst = '0, req1_dst = '0, req2_dst = '0;
  logic [3:0] req0_src = '0, req1_src = '0, req2_src = '0;
  logic       wb_stall = 1'b0;
  logic [3:0] MemtoReg;
  logic [4:0] WriteReg;
  logic       RegWrite, wb_busy, err_illegal;
  int n_chk = 0, n_fail = 0;
  int wlog[$];

  wb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_dst(req0_dst), .req1_dst(req1_dst), .req2_dst(req2_dst),
    .req0_src(req0_src), .req1_src(req1_src), .req2_src(req2_src),
    .wb_stall(wb_stall), .MemtoReg(MemtoReg), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .wb_busy(wb_busy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: winner is the first valid requester in the priority list
  function automatic logic [2:0] pick(input logic [2:0] v, input int p);
    int order[3];
`ifdef WB_RR_EN
    order = '{p % 3, (p + 1) % 3, (p + 2) % 3};
`else
    order = '{1, 2, 0};
`endif
    pick = '0;
    for (int i = 0; i < 3; i++)
      if (pick == 0 && v[order[i]]) pick[order[i]] = 1'b1;
  endfunction

  logic       m_valid;
  logic [4:0] m_dst;
  logic [3:0] m_src;
  int         m_ptr;
  logic [2:0] m_g;
  assign m_g = (reset_n && !wb_stall) ? pick(req_valid, m_ptr) : 3'b000;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_ptr   <= 1;
    end else begin
      m_valid <= |m_g;
      if (|m_g) begin
        m_dst <= m_g[1] ? req1_dst : m_g[2] ? req2_dst : req0_dst;
        m_src <= m_g[1] ? req1_src : m_g[2] ? req2_src : req0_src;
        m_ptr <= m_g[0] ? 1 : m_g[1] ? 2 : 0;
      end
    end

  always @(negedge clk)
    if (!reset_n) begin
      chk("rst_ready", 8'(req_ready), 8'd0);
      chk("rst_regwrite", 8'(RegWrite), 8'd0);
      chk("rst_writereg", 8'(WriteReg), 8'd0);
      chk("rst_memtoreg", 8'(MemtoReg), 8'd0);
      chk("rst_busy", 8'(wb_busy), 8'd0);
      chk("rst_err", 8'(err_illegal), 8'd0);
    end else begin
      chk("ready", 8'(req_ready), 8'(m_g));
      chk("regwrite", 8'(RegWrite), 8'(m_valid && m_dst != 0 && m_src <= 4'd8));
      chk("memtoreg", 8'(MemtoReg), (m_valid && m_src <= 4'd8) ? 8'(m_src) : 8'd0);
      chk("busy", 8'(wb_busy), 8'(m_valid));
      chk("err", 8'(err_illegal), 8'(m_valid && m_src > 4'd8));
      if (m_valid) chk("writereg", 8'(WriteReg), 8'(m_dst));
      if (RegWrite) wlog.push_back(int'(WriteReg));
    end

  task automatic step(input logic [2:0] v, input logic s);
    @(posedge clk);
    #2;
    req_valid = v;
    wb_stall  = s;
    #1;
  endtask

  initial begin
    int cnt[3];
    logic [2:0] prev;
    req_valid = 3'b111;
    repeat (2) @(posedge clk);
    #3;
    chk("lit_rst_ready", 8'(req_ready), 8'd0);
    chk("lit_rst_busy", 8'(wb_busy), 8'd0);
    req_valid = '0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    // single ALU request
    req0_dst = 5'd5; req0_src = 4'd0;
    step(3'b001, 1'b0);
    chk("lit_alu_ready", 8'(req_ready), 8'b001);
    step(3'b000, 1'b0);
    chk("lit_alu_regwrite", 8'(RegWrite), 8'd1);
    chk("lit_alu_writereg", 8'(WriteReg), 8'd5);
    chk("lit_alu_memtoreg", 8'(MemtoReg), 8'd0);
    step(3'b000, 1'b0);
    chk("lit_alu_idle", 8'(wb_busy), 8'd0);
    // simultaneous requests
    req1_dst = 5'd8; req1_src = 4'd1;
    req2_dst = 5'd9; req2_src = 4'd7;
    req0_dst = 5'd10; req0_src = 4'd0;
    wlog.delete();
    step(3'b111, 1'b0);
    chk("lit_all_ready", 8'(req_ready), 8'b010);
    step(3'b101, 1'b0);
    chk("lit_mdu_ready", 8'(req_ready), 8'b100);
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    chk("lit_third_writereg", 8'(WriteReg), 8'd10);
    step(3'b000, 1'b0);
    chk("lit_order_count", 8'(wlog.size()), 8'd3);
    if (wlog.size() == 3) begin
      chk("lit_order0", 8'(wlog[0]), 8'd8);
      chk("lit_order1", 8'(wlog[1]), 8'd9);
      chk("lit_order2", 8'(wlog[2]), 8'd10);
    end
    // stall holds off the grant
    req1_dst = 5'd12; req1_src = 4'd2;
    repeat (3) begin
      step(3'b010, 1'b1);
      chk("lit_stall_ready", 8'(req_ready), 8'd0);
    end
    step(3'b010, 1'b0);
    chk("lit_unstall_ready", 8'(req_ready), 8'b010);
    step(3'b000, 1'b1);
    chk("lit_stall_write", 8'(RegWrite), 8'd1);
    chk("lit_stall_writereg", 8'(WriteReg), 8'd12);
    chk("lit_stall_memtoreg", 8'(MemtoReg), 8'd2);
    step(3'b000, 1'b0);
    // dst=0 is accepted but not written
    req2_dst = 5'd0; req2_src = 4'd8;
    step(3'b100, 1'b0);
    chk("lit_dst0_ready", 8'(req_ready), 8'b100);
    step(3'b000, 1'b0);
    chk("lit_dst0_regwrite", 8'(RegWrite), 8'd0);
    chk("lit_dst0_busy", 8'(wb_busy), 8'd1);
    chk("lit_dst0_err", 8'(err_illegal), 8'd0);
    // illegal select code
    req0_dst = 5'd3; req0_src = 4'd10;
    step(3'b001, 1'b0);
    chk("lit_ill_ready", 8'(req_ready), 8'b001);
    step(3'b000, 1'b0);
    chk("lit_ill_err", 8'(err_illegal), 8'd1);
    chk("lit_ill_regwrite", 8'(RegWrite), 8'd0);
    chk("lit_ill_memtoreg", 8'(MemtoReg), 8'd0);
    step(3'b000, 1'b0);
    chk("lit_ill_pulse_end", 8'(err_illegal), 8'd0);
    // reset while a write is in flight
    req1_dst = 5'd7; req1_src = 4'd3;
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    chk("lit_pre_rst_write", 8'(RegWrite), 8'd1);
    reset_n = 1'b0;
    #1;
    chk("lit_mid_rst_regwrite", 8'(RegWrite), 8'd0);
    chk("lit_mid_rst_ready", 8'(req_ready), 8'd0);
    chk("lit_mid_rst_busy", 8'(wb_busy), 8'd0);
    req_valid = '0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(3'b000, 1'b0);
    chk("lit_post_rst_regwrite", 8'(RegWrite), 8'd0);
    chk("lit_post_rst_busy", 8'(wb_busy), 8'd0);
    // all three held valid for six cycles
    cnt = '{0, 0, 0};
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      step(3'b111, 1'b0);
`ifdef WB_RR_EN
      chk("lit_rr_repeat", 8'(req_ready == prev), 8'd0);
`else
      chk("lit_fixed_load", 8'(req_ready), 8'b010);
`endif
      for (int i = 0; i < 3; i++) if (req_ready[i]) cnt[i]++;
      prev = req_ready;
    end
`ifdef WB_RR_EN
    for (int i = 0; i < 3; i++) chk("lit_rr_count", 8'(cnt[i]), 8'd2);
`else
    chk("lit_fixed_count", 8'(cnt[1]), 8'd6);
`endif
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports req_valid, input, 3, one write-back request per requester: bit0 ALU, bit1 LOAD, bit2 MDU.
REQ-004 SHALL have ports req_ready, output, 3, grant/accept per requester.
REQ-005 SHALL have ports req0_dst, req1_dst, req2_dst, input, 5 each, destination register per requester.
REQ-006 SHALL have ports req0_src, req1_src, req2_src, input, 4 each, MemtoReg select code per requester.
REQ-007 SHALL have port wb_stall, input, 1; high blocks new grants.
REQ-008 SHALL have port MemtoReg, output, 4, select code to the write-back mux.
REQ-009 SHALL have port WriteReg, output, 5, register file write address.
REQ-010 SHALL have port RegWrite, output, 1, register file write enable.
REQ-011 SHALL have port wb_busy, output, 1, high while a write is in flight (state WRITE).
REQ-012 SHALL have port err_illegal, output, 1, one-cycle pulse on an illegal select code.

Function
REQ-013 SHALL use a two-state FSM: IDLE (no write in flight), WRITE (latched transaction driven to register file).
REQ-014 SHALL grant in cycle N when wb_stall=0 and req_valid!=0; exactly one req_ready bit high, combinationally, in that cycle only.
REQ-015 SHALL complete the handshake on req_valid[i] & req_ready[i]; the requester holds valid, dst and src stable until it is granted.
REQ-016 SHALL register the winner's dst/src on the grant edge and enter WRITE; RegWrite, WriteReg and MemtoReg are valid in cycle N+1, giving a fixed latency of 1.
REQ-017 SHALL allow back-to-back grants, one per cycle; a new grant in WRITE keeps the FSM in WRITE.
REQ-018 SHALL return to IDLE when no grant occurs; in IDLE, RegWrite=0 and MemtoReg=0000.
REQ-019 SHALL raise no req_ready while wb_stall=1; a transaction already latched still performs its write in the stall cycle.
REQ-020 SHALL accept a request with dst=0 normally, but SHALL hold RegWrite=0 for that slot.
REQ-021 SHALL treat src codes 0000-1000 as legal; codes 1001-1111 are accepted and drive RegWrite=0 and MemtoReg=0000, and SHALL pulse err_illegal in cycle N+1.
REQ-022 SHALL default to fixed priority LOAD > MDU > ALU.
REQ-023 SHALL have every output a pure function of registered state, except req_ready.

Reset
REQ-024 SHALL, when reset_n is low, force IDLE and set RegWrite=0, WriteReg=0, MemtoReg=0000, wb_busy=0, err_illegal=0 and req_ready=0 regardless of clk.
REQ-025 SHALL abandon any latched in-flight write on reset assertion mid-operation, with no write on release.
REQ-026 SHALL allow the first grant on the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL compile in round-robin arbitration when WB_RR_EN is defined: a 2-bit pointer names the highest-priority requester and advances to one past the last granted index; the pointer resets to LOAD.
REQ-028 SHALL use fixed priority per REQ-022, with no pointer state, when WB_RR_EN is undefined.

Structure
REQ-029 SHALL take from shared package wb_pkg:
- src code constants: ALU=0000, LOADSIZE=0001, MEMDATA=0010, RD=0011, SE1_32=0100, CONST227=0101, REGB=0110, HI=0111, LO=1000
- SRC_MAX=1000
- requester index constants
- FSM state typedef
REQ-030 SHALL place the priority/round-robin selection in one sub-module, wb_rr_picker (3-bit request in, one-hot grant out, pointer internal under WB_RR_EN).

Verification
REQ-031 SHALL cover single ALU request: req0 dst=5, src=0000 -> req_ready=001 in cycle N; in N+1 RegWrite=1, WriteReg=5, MemtoReg=0000; then IDLE.
REQ-032 SHALL cover simultaneous requests, fixed mode: all valid (LOAD dst=8/0001, MDU dst=9/0111, ALU dst=10/0000) -> writes in order 8, 9, 10 on three consecutive cycles.
REQ-033 SHALL cover stall: LOAD valid with wb_stall=1 for 3 cycles -> req_ready=000 throughout; grant on the cycle the stall drops; write one cycle later.
REQ-034 SHALL cover boundaries:
- MDU dst=0, src=1000 -> accepted, RegWrite=0
- ALU src=1010 -> accepted, err_illegal pulse, RegWrite=0
REQ-035 SHALL cover reset mid-write: assert reset_n=0 while in WRITE -> RegWrite=0 immediately; no write after release.
REQ-036 SHALL cover round robin with WB_RR_EN: all three held valid for 6 cycles -> each requester granted exactly twice, no requester granted twice in a row.
